// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one off-core memory port between NUM_CH cache
// refill/writeback requesters. A winner is picked in IDLE and its request is
// latched at grant. The transaction is issued and held until mem_ack. A
// one-cycle ch_ack then goes back to the winner.
// Optional build macro: MEM_ARB_FIXED_PRIO_EN. When it is defined, the lowest
// requesting index always wins and there is no round-robin pointer. When it is
// undefined (the default), arbitration is round-robin.
module mem_port_arbiter #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128,
  localparam int IDX_W = $clog2(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          ch_req,
  input  logic [NUM_CH-1:0]          ch_rw,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
  output logic [NUM_CH-1:0]          ch_ack,
  output logic [DATA_W-1:0]          ch_rdata,
  output logic [IDX_W-1:0]           grant_idx,
  output logic                       busy,
  output logic                       mem_enable,
  output logic                       mem_rw,
  input  logic                       mem_ack,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_data_in,
  input  logic [DATA_W-1:0]          mem_data_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rw_q, rw_d;
  logic [NUM_CH-1:0]   ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [IDX_W-1:0]    win_idx;
  logic                win_valid;

  // Per-channel views of the packed request buses.
  logic [ADDR_W-1:0]   addr_arr  [NUM_CH];
  logic [DATA_W-1:0]   wdata_arr [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign addr_arr[gi]  = ch_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = ch_wdata[gi*DATA_W +: DATA_W];
  end

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Fixed priority: scan from the top down so the lowest requesting index wins.
  always_comb begin
    win_idx   = '0;
    win_valid = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_req[IDX_W'(i)]) begin
        win_idx   = IDX_W'(i);
        win_valid = 1'b1;
      end
    end
  end
`else
  logic [IDX_W-1:0]    last_q, last_d;
  logic [IDX_W-1:0]    cand_idx;

  // Round-robin: scan offsets from farthest to nearest so the channel closest
  // after last_grant (modulo NUM_CH) overwrites the others and wins.
  always_comb begin
    win_idx   = '0;
    win_valid = 1'b0;
    cand_idx  = '0;
    for (int off = NUM_CH; off >= 1; off--) begin
      cand_idx = IDX_W'((int'(last_q) + off) % NUM_CH);
      if (ch_req[cand_idx]) begin
        win_idx   = cand_idx;
        win_valid = 1'b1;
      end
    end
  end

  // The pointer follows every grant made in IDLE.
  always_comb begin
    last_d = last_q;
    if (state_q == ST_IDLE && win_valid) begin
      last_d = win_idx;
    end
  end

  // Pointer register. It resets to the top index so channel 0 is searched first.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_q <= IDX_W'(NUM_CH - 1);
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Next-state logic: latch the request at grant and capture the response on mem_ack.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          grant_d = win_idx;
          addr_d  = addr_arr[win_idx];
          wdata_d = wdata_arr[win_idx];
          rw_d    = ch_rw[win_idx];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Requester inputs are ignored here. Only mem_ack ends the transaction.
        if (mem_ack) begin
          rdata_d        = mem_data_out;
          ack_d[grant_q] = 1'b1;
          state_d        = ST_RESP;
        end
      end
      ST_RESP: begin
        // Requests are not sampled here. This gives the acked channel one
        // cycle to drop its req before the next arbitration.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset abandons any in-flight transaction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      ack_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_enable  = (state_q == ST_ISSUE);
  assign busy        = (state_q != ST_IDLE);
  assign mem_rw      = rw_q;
  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;
  assign ch_ack      = ack_q;
  assign ch_rdata    = rdata_q;
  assign grant_idx   = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter.
// The main instance has 3 channels. A second instance with 5 channels checks
// pointer wrap-around. Build with MEM_ARB_FIXED_PRIO_EN to get the
// fixed-priority expectations.
module tb_mem_port_arbiter;

  localparam int NUM_CH = 3;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;
  localparam int IDX_W  = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH-1:0]        ch_rw;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [NUM_CH-1:0]        ch_ack;
  logic [DATA_W-1:0]        ch_rdata;
  logic [IDX_W-1:0]         grant_idx;
  logic                     busy;
  logic                     mem_enable;
  logic                     mem_rw;
  logic                     mem_ack;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_data_in;
  logic [DATA_W-1:0]        mem_data_out;

  // Five-channel instance used for the wrap-around case.
  logic                     reset5;
  logic [4:0]               req5, rw5, ack5;
  logic [5*ADDR_W-1:0]      addr5;
  logic [5*DATA_W-1:0]      wdata5;
  logic [DATA_W-1:0]        rdata5, mdin5, mdout5;
  logic [2:0]               grant5;
  logic                     busy5, en5, rwo5, mem_ack5;
  logic [ADDR_W-1:0]        maddr5;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
    .clk(clk), .reset(reset), .ch_req(ch_req), .ch_rw(ch_rw), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_ack(ch_ack), .ch_rdata(ch_rdata), .grant_idx(grant_idx),
    .busy(busy), .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  mem_port_arbiter #(.NUM_CH(5), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut5 (
    .clk(clk), .reset(reset5), .ch_req(req5), .ch_rw(rw5), .ch_addr(addr5),
    .ch_wdata(wdata5), .ch_ack(ack5), .ch_rdata(rdata5), .grant_idx(grant5),
    .busy(busy5), .mem_enable(en5), .mem_rw(rwo5), .mem_ack(mem_ack5),
    .mem_addr(maddr5), .mem_data_in(mdin5), .mem_data_out(mdout5)
  );

  typedef struct {
    int          idx;
    logic [31:0] addr;
    logic        rw;
    logic [127:0] wdata;
  } txn_t;

  txn_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   pend[NUM_CH];
  int   mem_lat  = 1;
  int   en_cnt   = 0;
  bit   force_ack = 1'b0;
  bit   prev_ack  = 1'b0;
  bit   spacing_chk = 1'b0;
  int   last_ack_cyc = -1;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Memory contents model: each line is derived from its address.
  function automatic logic [127:0] line_of(input logic [31:0] a);
    return {16{8'hA5}} ^ {96'd0, a};
  endfunction

  // Memory responder. It raises mem_ack in the mem_lat-th cycle that
  // mem_enable is seen. In every other cycle mem_data_out carries junk.
  task automatic respond();
    if (force_ack) begin
      mem_ack = 1'b1;
      mem_data_out = {$urandom, $urandom, $urandom, $urandom};
    end else if (mem_enable === 1'b1) begin
      en_cnt++;
      if (en_cnt == mem_lat) begin
        mem_ack = 1'b1;
        mem_data_out = line_of(mem_addr);
      end else begin
        mem_ack = 1'b0;
        mem_data_out = {$urandom, $urandom, $urandom, $urandom};
      end
    end else begin
      en_cnt = 0;
      mem_ack = 1'b0;
      mem_data_out = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  // Compare the DUT outputs against the head of the scoreboard.
  task automatic monitor();
    txn_t t;
    if (reset !== 1'b1) begin
      prev_ack = 1'b0;
      return;
    end
    if (prev_ack) begin
      check_val("ack_one_cycle", ch_ack, 0);
      check_val("busy_after_resp", busy, 0);
      check_val("enable_after_resp", mem_enable, 0);
      prev_ack = 1'b0;
    end else if (ch_ack !== '0) begin
      if (sb_q.size() == 0) begin
        check_val("spurious_ack", ch_ack, 0);
      end else begin
        t = sb_q.pop_front();
        check_val("ack_onehot", ch_ack, 128'(1) << t.idx);
        check_val("ack_busy", busy, 1);
        check_val("ack_enable_low", mem_enable, 0);
        if (!t.rw) check_val("rdata", ch_rdata, line_of(t.addr));
        if (spacing_chk && last_ack_cyc >= 0) check_val("ack_spacing", cyc - last_ack_cyc, 3);
        last_ack_cyc = cyc;
        if (pend[t.idx] > 0) pend[t.idx]--;
        if (pend[t.idx] == 0) ch_req[t.idx] = 1'b0;
        prev_ack = 1'b1;
      end
    end
    if (mem_enable === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_val("spurious_issue", mem_enable, 0);
      end else begin
        t = sb_q[0];
        check_val("grant_idx", grant_idx, t.idx);
        check_val("mem_addr", mem_addr, t.addr);
        check_val("mem_rw", mem_rw, t.rw);
        check_val("mem_data_in", mem_data_in, t.wdata);
        check_val("issue_busy", busy, 1);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    monitor();
    respond();
  endtask

  task automatic set_ch(input int i, input logic rw, input logic [31:0] a, input logic [127:0] d);
    ch_rw[i] = rw;
    ch_addr[i*ADDR_W +: ADDR_W] = a;
    ch_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic request(input int i, input int n);
    ch_req[i] = 1'b1;
    pend[i] = n;
  endtask

  task automatic expect_txn(input int i);
    txn_t t;
    t.idx   = i;
    t.addr  = ch_addr[i*ADDR_W +: ADDR_W];
    t.rw    = ch_rw[i];
    t.wdata = ch_wdata[i*DATA_W +: DATA_W];
    sb_q.push_back(t);
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && (sb_q.size() != 0 || busy !== 1'b0 || prev_ack); i++) tick();
    check_val("drain", sb_q.size(), 0);
  endtask

  task automatic wait_issue(input int bound);
    for (int i = 0; i < bound && mem_enable !== 1'b1; i++) tick();
    check_val("issue_seen", mem_enable, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_mem_enable"}, mem_enable, 0);
    check_val({tag, "_mem_rw"}, mem_rw, 0);
    check_val({tag, "_mem_addr"}, mem_addr, 0);
    check_val({tag, "_mem_data_in"}, mem_data_in, 0);
    check_val({tag, "_ch_ack"}, ch_ack, 0);
    check_val({tag, "_ch_rdata"}, ch_rdata, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_grant_idx"}, grant_idx, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; reset5 = 1'b0;
    ch_req = '0; ch_rw = '0; ch_addr = '0; ch_wdata = '0;
    mem_ack = 1'b0; mem_data_out = '0;
    req5 = '0; rw5 = '0; addr5 = '0; wdata5 = '0; mem_ack5 = 1'b0; mdout5 = '0;
    for (int i = 0; i < NUM_CH; i++) pend[i] = 0;

    // Reset held low for 3 cycles with requests pending and mem_ack forced high.
    force_ack = 1'b1;
    ch_req = 3'b111;
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 1'b1, 32'h40 + i, 128'h77 + i);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_all_zero("reset");
    end
    ch_req = '0;
    force_ack = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check_all_zero("post_reset");

    // Single read on ch0 with a 4-cycle memory latency.
    mem_lat = 4;
    set_ch(0, 1'b0, 32'h100, 128'h1111);
    request(0, 1);
    expect_txn(0);
    drain(40);

    // Write on ch2. The address and data change after grant and must be ignored.
    set_ch(2, 1'b1, 32'h200, 128'hDEAD);
    request(2, 1);
    expect_txn(2);
    wait_issue(10);
    set_ch(2, 1'b1, 32'h300, 128'hBEEF);
    drain(40);

    // All three channels request back to back with a 1-cycle memory latency.
    mem_lat = 1;
    spacing_chk = 1'b1;
    last_ack_cyc = -1;
    for (int i = 0; i < NUM_CH; i++) begin
      set_ch(i, 1'b0, 32'h1000 + 32'(i) * 32'h40, 128'h5000 + 128'(i));
      request(i, 2);
    end
`ifdef MEM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_CH; i++) begin
      expect_txn(i);
      expect_txn(i);
    end
`else
    for (int r = 0; r < 2; r++) for (int i = 0; i < NUM_CH; i++) expect_txn(i);
`endif
    drain(60);
    spacing_chk = 1'b0;

    // Reset asserted in the second ISSUE cycle of a ch1 read.
    mem_lat = 50;
    set_ch(1, 1'b0, 32'h180, 128'h2222);
    request(1, 1);
    expect_txn(1);
    wait_issue(10);
    tick();
    reset = 1'b0;
    tick();
    check_val("abort_enable", mem_enable, 0);
    check_val("abort_ack", ch_ack, 0);
    check_val("abort_busy", busy, 0);
    sb_q.delete();
    ch_req = '0;
    pend[1] = 0;
    tick();
    check_val("abort_hold_ack", ch_ack, 0);
    reset = 1'b1;
    // After reset the pointer starts at the top again, so ch1 is granted before ch2.
    mem_lat = 2;
    set_ch(1, 1'b0, 32'h1C0, 128'h3333);
    set_ch(2, 1'b1, 32'h2C0, 128'h4444);
    request(1, 1);
    request(2, 1);
    expect_txn(1);
    expect_txn(2);
    drain(40);

    // Five-channel instance: ch4 alone first, then ch4 and ch0 together, which wraps to ch0.
    for (int i = 0; i < 5; i++) addr5[i*ADDR_W +: ADDR_W] = 32'hA00 + 32'(i);
    tick();
    reset5 = 1'b1;
    req5 = 5'b10000;
    for (int i = 0; i < 10 && en5 !== 1'b1; i++) tick();
    check_val("p5_first_issue", en5, 1);
    check_val("p5_first_grant", grant5, 4);
    mem_ack5 = 1'b1;
    mdout5 = line_of(32'hA04);
    tick();
    mem_ack5 = 1'b0;
    check_val("p5_ack4", ack5, 5'b10000);
    check_val("p5_rdata4", rdata5, line_of(32'hA04));
    req5 = '0;
    tick();
    tick();
    req5 = 5'b10001;
    for (int i = 0; i < 10 && en5 !== 1'b1; i++) tick();
    check_val("p5_wrap_grant", grant5, 0);
    check_val("p5_wrap_addr", maddr5, 32'hA00);
    mem_ack5 = 1'b1;
    mdout5 = line_of(32'hA00);
    tick();
    mem_ack5 = 1'b0;
    check_val("p5_ack0", ack5, 5'b00001);
    req5 = '0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
